// File: rtl/bench_pkg.sv
// Shared definitions for the benchmark capture mux: mode encodings and mode type.
package bench_pkg;

  typedef enum logic [1:0] {
    MODE_LIVE = 2'b00,
    MODE_HOLD = 2'b01,
    MODE_SCAN = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

endpackage

// File: rtl/scan_sequencer.sv
// Autonomous channel sweep: dwell counter, wrapping channel index, entry detection
// and step generation. Outputs are the values the top registers on this edge.
module scan_sequencer
  import bench_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int DWELL  = 4,
  localparam int SEL_W = $clog2(NUM_CH),
  localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  mode_e            mode,
  output logic [SEL_W-1:0] scan_idx,
  output logic             step
);

  logic [SEL_W-1:0] idx_q, idx_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  mode_e            prev_mode_q, prev_mode_d;
  logic             adv;

  always_comb begin
    idx_d       = idx_q;
    dwell_d     = dwell_q;
    adv         = 1'b0;
    prev_mode_d = mode;
    // Outside SCAN the state is frozen; a fresh entry always restarts at channel 0.
    if (mode == MODE_SCAN) begin
      if (prev_mode_q != MODE_SCAN) begin
        idx_d   = '0;
        dwell_d = '0;
      end else if (dwell_q == DW_W'(DWELL - 1)) begin
        dwell_d = '0;
        adv     = 1'b1;
        idx_d   = (idx_q == SEL_W'(NUM_CH - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        dwell_d = dwell_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q       <= '0;
      dwell_q     <= '0;
      prev_mode_q <= MODE_LIVE;
    end else begin
      idx_q       <= idx_d;
      dwell_q     <= dwell_d;
      prev_mode_q <= prev_mode_d;
    end
  end

  // Next index, so the top can load the matching data in the same edge.
  assign scan_idx = idx_d;
  assign step     = adv;

endmodule

// File: rtl/bench_capture_mux.sv
// Routes one of NUM_CH benchmark result buses to the output pins, with live,
// snapshot-hold and autonomous scan modes. All outputs are registered.
module bench_capture_mux
  import bench_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int CH_W   = 8,
  parameter int DWELL  = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CH*CH_W-1:0] ch_data,
  input  logic [SEL_W-1:0]       sel,
  input  logic [1:0]             mode,
  input  logic                   capture,
  output logic [CH_W-1:0]        data_out,
  output logic [SEL_W-1:0]       ch_idx,
  output logic                   snap_valid,
  output logic                   step
);

  mode_e            mode_s;
  logic [CH_W-1:0]  ch_arr [NUM_CH];
  logic [CH_W-1:0]  snap_q [NUM_CH];
  logic [CH_W-1:0]  snap_d [NUM_CH];
  logic [CH_W-1:0]  live_sel, snap_sel, scan_sel;
  logic [SEL_W-1:0] scan_idx;
  logic             scan_step;

  logic [CH_W-1:0]  data_out_q, data_out_d;
  logic [SEL_W-1:0] ch_idx_q, ch_idx_d;
  logic             snap_valid_q, snap_valid_d;
  logic             step_q, step_d;

  assign mode_s = mode_e'(mode);

  scan_sequencer #(
    .NUM_CH (NUM_CH),
    .DWELL  (DWELL)
  ) u_scan_sequencer (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode_s),
    .scan_idx (scan_idx),
    .step     (scan_step)
  );

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      ch_arr[k] = ch_data[k*CH_W +: CH_W];
    end
  end

  // Compare-based selection: an out-of-range sel matches no channel and yields 0.
  always_comb begin
    live_sel = '0;
    snap_sel = '0;
    scan_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel == SEL_W'(k)) begin
        live_sel = ch_arr[k];
        snap_sel = snap_q[k];
      end
      if (scan_idx == SEL_W'(k)) begin
        scan_sel = ch_arr[k];
      end
    end
  end

  always_comb begin
    snap_d       = capture ? ch_arr : snap_q;
    snap_valid_d = snap_valid_q | capture;
    data_out_d   = live_sel;
    ch_idx_d     = sel;
    step_d       = 1'b0;
    case (mode_s)
      MODE_HOLD: begin
        // A capture in HOLD bypasses the snapshot so the new value shows immediately.
        if (capture) begin
          data_out_d = live_sel;
        end else if (snap_valid_q) begin
          data_out_d = snap_sel;
        end else begin
          data_out_d = '0;
        end
      end
      MODE_SCAN: begin
        data_out_d = scan_sel;
        ch_idx_d   = scan_idx;
        step_d     = scan_step;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        snap_q[k] <= '0;
      end
      snap_valid_q <= 1'b0;
      data_out_q   <= '0;
      ch_idx_q     <= '0;
      step_q       <= 1'b0;
    end else begin
      snap_q       <= snap_d;
      snap_valid_q <= snap_valid_d;
      data_out_q   <= data_out_d;
      ch_idx_q     <= ch_idx_d;
      step_q       <= step_d;
    end
  end

  assign data_out   = data_out_q;
  assign ch_idx     = ch_idx_q;
  assign snap_valid = snap_valid_q;
  assign step       = step_q;

endmodule

// File: tb/tb_bench_capture_mux.sv
// Directed bench: an 8-channel/DWELL=4 instance and a 5-channel/DWELL=3 instance,
// with expected outputs queued at stimulus time and checked after each edge.
module tb_bench_capture_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: NUM_CH=8, DWELL=4
  logic        ra;
  logic [63:0] a_ch;
  logic [2:0]  a_sel;
  logic [1:0]  a_mode;
  logic        a_cap;
  logic [7:0]  a_dout;
  logic [2:0]  a_idx;
  logic        a_sv, a_st;

  // Instance B: NUM_CH=5, DWELL=3
  logic        rb;
  logic [39:0] b_ch;
  logic [2:0]  b_sel;
  logic [1:0]  b_mode;
  logic        b_cap;
  logic [7:0]  b_dout;
  logic [2:0]  b_idx;
  logic        b_sv, b_st;

  bench_capture_mux #(.NUM_CH(8), .CH_W(8), .DWELL(4)) u_a (
    .clk(clk), .reset(ra), .ch_data(a_ch), .sel(a_sel), .mode(a_mode),
    .capture(a_cap), .data_out(a_dout), .ch_idx(a_idx), .snap_valid(a_sv), .step(a_st)
  );

  bench_capture_mux #(.NUM_CH(5), .CH_W(8), .DWELL(3)) u_b (
    .clk(clk), .reset(rb), .ch_data(b_ch), .sel(b_sel), .mode(b_mode),
    .capture(b_cap), .data_out(b_dout), .ch_idx(b_idx), .snap_valid(b_sv), .step(b_st)
  );

  typedef struct {
    string      tag;
    bit         b;
    logic [7:0] d;
    logic [2:0] i;
    logic       sv;
    logic       st;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [63:0] pat8(input logic [7:0] base);
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[k*8 +: 8] = base + 8'(k);
    return v;
  endfunction

  function automatic logic [39:0] pat5(input logic [7:0] base);
    logic [39:0] v;
    for (int k = 0; k < 5; k++) v[k*8 +: 8] = base + 8'(k);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Queue the expectation, clock once, then compare the popped entry against the DUT.
  task automatic cyc(input bit b, input string tag, input logic [7:0] d, input logic [2:0] i,
                     input logic sv, input logic st);
    exp_t e;
    e.tag = tag; e.b = b; e.d = d; e.i = i; e.sv = sv; e.st = st;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.b) begin
      chk({e.tag, ".data"}, 32'(b_dout), 32'(e.d));
      chk({e.tag, ".idx"},  32'(b_idx),  32'(e.i));
      chk({e.tag, ".snapv"}, 32'(b_sv),  32'(e.sv));
      chk({e.tag, ".step"}, 32'(b_st),   32'(e.st));
    end else begin
      chk({e.tag, ".data"}, 32'(a_dout), 32'(e.d));
      chk({e.tag, ".idx"},  32'(a_idx),  32'(e.i));
      chk({e.tag, ".snapv"}, 32'(a_sv),  32'(e.sv));
      chk({e.tag, ".step"}, 32'(a_st),   32'(e.st));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    ra = 1'b1; a_ch = pat8(8'h10); a_sel = 3'd5; a_mode = 2'b00; a_cap = 1'b0;
    rb = 1'b1; b_ch = pat5(8'h30); b_sel = 3'd0; b_mode = 2'b00; b_cap = 1'b0;

    // ---- Instance A: reset, LIVE, HOLD, capture ----
    cyc(0, "a_reset", 8'h00, 3'd0, 1'b0, 1'b0);
    ra = 1'b0;
    cyc(0, "a_live5", 8'h15, 3'd5, 1'b0, 1'b0);
    a_sel = 3'd7;
    cyc(0, "a_live7", 8'h17, 3'd7, 1'b0, 1'b0);
    a_mode = 2'b11; a_sel = 3'd3;
    cyc(0, "a_rsvd3", 8'h13, 3'd3, 1'b0, 1'b0);
    a_mode = 2'b01; a_sel = 3'd2;
    cyc(0, "a_hold_nosnap", 8'h00, 3'd2, 1'b0, 1'b0);
    a_ch = pat8(8'hA0); a_cap = 1'b1;
    cyc(0, "a_hold_bypass", 8'hA2, 3'd2, 1'b1, 1'b0);
    a_cap = 1'b0; a_ch = pat8(8'h00);
    cyc(0, "a_hold_keep", 8'hA2, 3'd2, 1'b1, 1'b0);
    a_sel = 3'd6;
    cyc(0, "a_hold_sel6", 8'hA6, 3'd6, 1'b1, 1'b0);
    a_ch = pat8(8'hB0); a_cap = 1'b1;
    cyc(0, "a_cap_b", 8'hB6, 3'd6, 1'b1, 1'b0);
    a_ch = pat8(8'hC0);
    cyc(0, "a_cap_c", 8'hC6, 3'd6, 1'b1, 1'b0);
    a_cap = 1'b0; a_ch = pat8(8'h00);
    cyc(0, "a_last_wins", 8'hC6, 3'd6, 1'b1, 1'b0);
    a_mode = 2'b00;
    cyc(0, "a_live6", 8'h06, 3'd6, 1'b1, 1'b0);

    // ---- Instance A: reset beats capture ----
    ra = 1'b1; a_cap = 1'b1; a_ch = pat8(8'hD0);
    cyc(0, "a_rst_cap", 8'h00, 3'd0, 1'b0, 1'b0);
    ra = 1'b0; a_cap = 1'b0; a_mode = 2'b01; a_sel = 3'd1;
    cyc(0, "a_prio_hold", 8'h00, 3'd1, 1'b0, 1'b0);

    // ---- Instance A: SCAN with DWELL=4 ----
    a_ch = pat8(8'h10); a_mode = 2'b10;
    for (int c = 0; c < 9; c++) begin
      cyc(0, $sformatf("a_scan%0d", c), 8'h10 + 8'(c / 4), 3'(c / 4), 1'b0,
          (c > 0) && (c % 4 == 0));
    end

    // ---- Instance B: reset, out-of-range, SCAN wrap ----
    b_mode = 2'b00; b_sel = 3'd6;
    cyc(1, "b_reset", 8'h00, 3'd0, 1'b0, 1'b0);
    rb = 1'b0;
    cyc(1, "b_oor6", 8'h00, 3'd6, 1'b0, 1'b0);
    b_sel = 3'd4;
    cyc(1, "b_live4", 8'h34, 3'd4, 1'b0, 1'b0);
    b_mode = 2'b10; b_cap = 1'b1;
    for (int c = 0; c < 16; c++) begin
      cyc(1, $sformatf("b_scan%0d", c), 8'h30 + 8'((c / 3) % 5), 3'((c / 3) % 5), 1'b1,
          (c > 0) && (c % 3 == 0));
      b_cap = 1'b0;
    end

    // ---- Instance B: leave and re-enter SCAN ----
    b_mode = 2'b00; b_sel = 3'd1;
    cyc(1, "b_leave", 8'h31, 3'd1, 1'b1, 1'b0);
    b_mode = 2'b10;
    for (int c = 0; c < 10; c++) begin
      cyc(1, $sformatf("b_rescan%0d", c), 8'h30 + 8'(c / 3), 3'(c / 3), 1'b1,
          (c > 0) && (c % 3 == 0));
    end

    // ---- Instance B: reset mid-scan at channel 3, then restart ----
    rb = 1'b1;
    cyc(1, "b_rst_scan", 8'h00, 3'd0, 1'b0, 1'b0);
    rb = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cyc(1, $sformatf("b_restart%0d", c), 8'h30 + 8'(c / 3), 3'(c / 3), 1'b0,
          (c > 0) && (c % 3 == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bench_capture_mux.md
# bench_capture_mux

Parametrised successor to the benchmark output selector. It routes one of NUM_CH benchmark result buses to the shared output pins, and adds three things the fixed 8-way selector lacks: a registered output, a global snapshot-and-hold capture, and an autonomous scan mode that steps through every channel. It sits between the benchmark instances and the top-level `io_out` pins.

## Interface
Parameters:
- NUM_CH, 8, number of benchmark channels; must be ≥ 2, need not be a power of two.
- CH_W, 8, width of each channel result bus.
- DWELL, 4, cycles each channel is shown in SCAN mode; must be ≥ 1.
- SEL_W, $clog2(NUM_CH), derived select width; do not override.

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- reset, in, 1: synchronous, active-high reset.
- ch_data, in, NUM_CH*CH_W: concatenated channel buses; channel k occupies bits [k*CH_W +: CH_W].
- sel, in, SEL_W: channel select used in LIVE and HOLD modes.
- mode, in, 2: 00 LIVE, 01 HOLD, 10 SCAN, 11 reserved (behaves as LIVE).
- capture, in, 1: single-cycle strobe that snapshots all channels.
- data_out, out, CH_W: registered selected result.
- ch_idx, out, SEL_W: channel index that data_out currently reflects.
- snap_valid, out, 1: high once at least one capture has occurred since reset.
- step, out, 1: one-cycle pulse on the cycle that ch_idx advances in SCAN mode.

## Operation
- **LIVE:** data_out ← ch_data[sel]; ch_idx ← sel.
- **HOLD:** data_out ← snap[sel]; ch_idx ← sel.
  - If snap_valid = 0, data_out ← 0.
- **capture:** in any mode, all NUM_CH snapshot registers load ch_data; snap_valid ← 1.
  - Bypass: if capture = 1 while in HOLD, data_out ← ch_data[sel] that same edge. The freshly captured value is therefore never shown late.
- **SCAN:** an internal scan_idx and a dwell counter (0..DWELL-1) run.
  - data_out ← ch_data[scan_idx]; ch_idx ← scan_idx.
  - When the dwell count reaches DWELL-1, it returns to 0, scan_idx increments, and step pulses.
  - scan_idx wraps from NUM_CH-1 to 0.
- **Entering SCAN** (mode differed on the previous cycle): scan_idx and the dwell counter both restart at 0. No step pulse is generated on entry.
- **Leaving SCAN:** the scan state is frozen and is irrelevant until SCAN is re-entered.
- **Out-of-range sel** (sel ≥ NUM_CH, only possible when NUM_CH is not a power of two): data_out ← 0; ch_idx ← sel.
- **mode = 11:** identical to LIVE.
- **Reset** (all synchronous):
  - data_out = 0, ch_idx = 0, snap_valid = 0, step = 0.
  - All snapshot registers = 0; scan_idx = 0; dwell counter = 0.
  - Reset has priority over capture and over a mode change in the same cycle.
  - Reset asserted mid-scan or mid-hold discards all state.

## Timing
- LIVE/HOLD latency: 1 cycle from sel/ch_data to data_out.
- HOLD latency with capture bypass: 1 cycle from capture to data_out.
- A mode change takes effect on the next edge.
- SCAN:
  - Channel 0 appears on data_out 1 edge after entry.
  - Each channel is held exactly DWELL cycles.
  - A full sweep takes NUM_CH*DWELL cycles.
- DWELL = 1: scan_idx advances every cycle, and step is high continuously after the first cycle.
- step is registered and coincides with the edge at which ch_idx takes the new index.
- A capture asserted on consecutive cycles reloads on every cycle; the last one wins.

## Structure
- Shared package bench_pkg holds:
  - the mode encodings: MODE_LIVE, MODE_HOLD, MODE_SCAN, MODE_RSVD;
  - the 2-bit mode type.
- Sub-module scan_sequencer holds the dwell counter, the scan_idx counter with non-power-of-two wrap, the entry detection (a registered previous mode), and step generation.
  - Parameters: NUM_CH, DWELL.
  - Outputs: scan_idx, step.
- Top level holds the snapshot register array, the output mux and the output registers.

## Test plan
- **LIVE select:** NUM_CH=8, ch_data[k] = 8'h10+k, sel=5. Expect data_out = 8'h15 and ch_idx = 5 one cycle later. Then sel=7 → 8'h17.
- **HOLD:**
  - mode=HOLD before any capture → data_out = 0, snap_valid = 0.
  - Pulse capture with ch_data[k] = 8'hA0+k, sel=2 → data_out = 8'hA2 the next cycle, snap_valid = 1.
  - Change ch_data to 8'h00+k → data_out stays 8'hA2.
  - sel=6 → 8'hA6.
- **SCAN, NUM_CH=5, DWELL=3:**
  - ch_idx follows 0,0,0,1,1,1,…,4,4,4,0.
  - step pulses exactly when ch_idx changes, including on the 4→0 wrap.
- **Out-of-range, NUM_CH=5:** sel=6 in LIVE → data_out = 0, ch_idx = 6.
- **Reset mid-scan:** assert reset while ch_idx = 3 → all outputs are 0 the next cycle and snap_valid = 0. Release reset with mode still SCAN → the sweep restarts at channel 0.
- **Priority:** reset and capture asserted together → snap_valid stays 0 and data_out stays 0 after a following switch to HOLD.
